// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with pc, req/ack imem port, fetch fifo and redirect flush
package if_fetch_pkg;
  typedef struct packed {
    logic [31:0] ia_plus_4;
    logic [31:0] ir;
  } id_params_t;
endpackage

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output id_params_t  id_params,
  output logic        id_valid
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  typedef enum logic {FETCH, FLUSH} state_t;
  state_t        state, state_nxt;
  logic          outstanding;
  logic [31:0]   pc, req_addr;
  id_params_t    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, issue;
  always_ff @(posedge clk)
    state <= rst ? FETCH : state_nxt;
  always_comb
    state_nxt = (state == FETCH) ? ((redirect && outstanding && !imem_ack) ? FLUSH : FETCH)
                                 : (imem_ack ? FETCH : FLUSH);
  always_comb begin
    imem_req  = outstanding;
    imem_addr = outstanding ? req_addr : pc;
    push      = state == FETCH && outstanding && imem_ack && !redirect;
    pop       = !stall && count != '0;
    issue     = state == FETCH && !outstanding && !redirect && count < FULL;
    id_valid  = count != '0;
    id_params = id_valid ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc          <= RESET_VECTOR;
      req_addr    <= RESET_VECTOR;
      outstanding <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= pc;
      end else if (outstanding && imem_ack) begin
        outstanding <= 1'b0;
      end
      pc <= redirect ? (redirect_target & ~32'h3) : push ? pc + 32'd4 : pc;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        count  <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {pc + 32'd4, imem_rdata};
  assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized scoreboard bench for if_fetch against a sequential-stream reference model
module tb_if_fetch;
  import if_fetch_pkg::*;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  logic        clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  logic        imem_req, imem_ack = 1'b0, stall = 1'b0, redirect = 1'b0, id_valid;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_target = '0;
  id_params_t  id_params;
  logic        req2, valid2;
  logic [31:0] addr2, rdata2;
  id_params_t  params2;
  int          n_cmp = 0, n_bad = 0;
  bit          auto_mem = 1'b1;
  int          lat_max = 0;
  id_params_t  exp_q[$];
  logic [31:0] gen_pc = RV;
  logic [31:0] req_log[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1111_0001 + (a >> 2);
  endfunction
  assign rdata2 = word(addr2);
  if_fetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .id_params(id_params), .id_valid(id_valid));
  if_fetch #(.RESET_VECTOR(32'hFFFF_FFFC), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_ack(req2),
    .imem_rdata(rdata2), .stall(1'b0), .redirect(1'b0), .redirect_target(32'h0),
    .id_params(params2), .id_valid(valid2));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        return;
      end
      tick;
    end
  endtask
  initial begin
    int  d;
    bit  pend;
    d = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_mem) pend = 1'b0;
      else if (rst || !imem_req) begin
        pend = 1'b0;
        imem_ack = 1'b0;
      end else begin
        if (!pend) begin
          pend = 1'b1;
          d = $urandom_range(lat_max, 0);
        end
        if (d == 0) begin
          imem_ack = 1'b1;
          imem_rdata = word(imem_addr);
          pend = 1'b0;
        end else begin
          imem_ack = 1'b0;
          d--;
        end
      end
    end
  end
  initial begin
    logic        p_rst, p_req, p_ack, p_redirect, p_valid, p_stall;
    logic [31:0] p_addr;
    id_params_t  p_params, e;
    p_rst = 1'b1; p_req = 1'b0; p_ack = 1'b0; p_redirect = 1'b0; p_valid = 1'b0; p_stall = 1'b0;
    p_addr = '0; p_params = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        gen_pc = RV;
      end else begin
        if (p_req && !p_ack && !p_rst) begin
          check("req_hold", imem_req, 1);
          check("addr_hold", imem_addr, p_addr);
        end
        if (p_redirect && !p_rst) check("flush_valid", id_valid, 0);
        if (!id_valid) check("bubble_params", id_params, 0);
        if (p_valid && p_stall && !p_redirect && !p_rst && id_valid) check("stall_hold", id_params, p_params);
        if (imem_req) check("addr_align", imem_addr[1:0], 0);
        if (imem_req && !(p_req && !p_ack && !p_rst)) req_log.push_back(imem_addr);
        if (id_valid && !stall) begin
          e = exp_q.pop_front();
          check("stream", id_params, e);
        end
        if (redirect) begin
          exp_q.delete();
          gen_pc = redirect_target & ~32'h3;
        end
      end
      while (exp_q.size() < 8) begin
        exp_q.push_back(id_params_t'({gen_pc + 32'd4, word(gen_pc)}));
        gen_pc += 32'd4;
      end
      p_rst = rst; p_req = imem_req; p_ack = imem_ack; p_redirect = redirect;
      p_valid = id_valid; p_stall = stall; p_addr = imem_addr; p_params = id_params;
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end
  initial begin
    int n;
    bit ok;
    repeat (3) tick;
    @(negedge clk);
    check("reset_req", imem_req, 0);
    check("reset_addr", imem_addr, RV);
    check("reset_valid", id_valid, 0);
    check("reset_params", id_params, 0);
    req_log.delete();
    tick;
    rst = 1'b0;
    @(negedge clk);
    n = 0;
    while (!id_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_latency", n, 2);
    check("first_params", id_params, {32'h4, 32'h1111_0001});
    repeat (8) tick;
    for (int k = 0; k < 3; k++)
      check($sformatf("fetch_addr%0d", k), k < req_log.size() ? req_log[k] : 32'hDEAD_DEAD, 32'(4 * k));
    stall = 1'b1;
    repeat (6) tick;
    @(negedge clk);
    check("full_req_drop", imem_req, 0);
    check("full_valid", id_valid, 1);
    tick;
    stall = 1'b0;
    repeat (8) tick;
    redirect = 1'b1;
    redirect_target = 32'h1000;
    tick;
    redirect = 1'b0;
    repeat (6) tick;
    auto_mem = 1'b0;
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'h10;
    tick;
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req && imem_addr != 32'h10) begin
        imem_ack = 1'b1;
        imem_rdata = word(imem_addr);
        tick;
        imem_ack = 1'b0;
      end else if (imem_req) ok = 1'b1;
      else tick;
    end
    check("t3_req_at_10", ok, 1);
    tick;
    redirect = 1'b1;
    redirect_target = 32'h200;
    tick;
    redirect = 1'b0;
    @(negedge clk);
    check("t3_hold_req", imem_req, 1);
    check("t3_hold_addr", imem_addr, 32'h10);
    check("t3_valid", id_valid, 0);
    tick;
    imem_ack = 1'b1;
    imem_rdata = word(32'h10);
    @(negedge clk);
    check("t3_ack_addr", imem_addr, 32'h10);
    tick;
    imem_ack = 1'b0;
    @(negedge clk);
    check("t3_discard", id_valid, 0);
    tick;
    wait_req(ok);
    check("t3_new_req", ok, 1);
    check("t3_new_addr", imem_addr, 32'h200);
    auto_mem = 1'b1;
    stall = 1'b1;
    repeat (8) tick;
    @(negedge clk);
    check("t4_valid_before", id_valid, 1);
    tick;
    redirect = 1'b1;
    redirect_target = 32'h0000_0103;
    tick;
    redirect = 1'b0;
    @(negedge clk);
    check("t4_valid", id_valid, 0);
    check("t4_params", id_params, 0);
    tick;
    wait_req(ok);
    check("t4_new_req", ok, 1);
    check("t4_new_addr", imem_addr, 32'h100);
    stall = 1'b0;
    tick;
    rst2 = 1'b0;
    @(negedge clk);
    n = 0;
    while (!valid2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_latency", n, 2);
    check("t5_params", params2, {32'h0, word(32'hFFFF_FFFC)});
    n = 0;
    while (!req2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_req", req2, 1);
    check("t5_next_addr", addr2, 32'h0);
    tick;
    auto_mem = 1'b0;
    imem_ack = 1'b0;
    wait_req(ok);
    check("t6_pending", ok, 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t6_req", imem_req, 0);
    check("t6_addr", imem_addr, RV);
    check("t6_valid", id_valid, 0);
    tick;
    imem_ack = 1'b0;
    @(negedge clk);
    check("t6_ignored", id_valid, 0);
    check("t6_refetch_req", imem_req, 1);
    check("t6_refetch_addr", imem_addr, RV);
    auto_mem = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick;
      stall = $urandom_range(99, 0) < 30;
      redirect = $urandom_range(99, 0) < 4;
      redirect_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      rst = $urandom_range(999, 0) < 3;
      if (c % 200 == 0) lat_max = $urandom_range(3, 0);
    end
    tick;
    stall = 1'b0;
    redirect = 1'b0;
    rst = 1'b0;
    repeat (10) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
